tetris_input_ctrl: RTL and testbench

- Produces the per-cycle control strobes consumed by the Tetris game logic: left_final, right_final, rot_final and tick_gravity.
- Conditions the three raw active-low push-buttons with a 2-flop synchronizer, a debouncer and a press-edge detector.
- Adds auto-repeat on the left/right strobes.
- Generates the gravity tick, whose period shortens as score rises.
- Sits between the board KEY pins and the gamelogic FSM.

---
 rtl/tetris_input_ctrl_pkg.sv | 19 +
 rtl/tetris_input_ctrl_if.sv | 24 ++
 rtl/tetris_input_ctrl_debounce.sv | 60 ++++++
 rtl/tetris_input_ctrl.sv | 154 +++++++++++++++
 tb/tb_tetris_input_ctrl.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/tetris_input_ctrl_pkg.sv
// Shared constants and types for the Tetris input controller.
package tetris_pkg;

   localparam int DEBOUNCE_CYC_DEF = 1_000_000;
   localparam int REPEAT_DELAY_DEF = 15_000_000;
   localparam int REPEAT_RATE_DEF  = 5_000_000;
   localparam int GRAV_BASE_DEF    = 25_000_000;
   localparam int GRAV_STEP_DEF    = 1_000_000;
   localparam int GRAV_MIN_DEF     = 5_000_000;
   localparam int CNT_W_DEF        = 26;
   localparam int SCORE_W          = 5;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DELAY  = 2'd1,
      REPEAT = 2'd2
   } rptState_t;

endpackage

// File: rtl/tetris_input_ctrl_if.sv
// Bundle of key inputs, game status and control strobes between the board and the gamelogic.
interface tetris_input_ctrl_if;

   logic                           key_left_n;
   logic                           key_right_n;
   logic                           key_rot_n;
   logic                           gravity_en;
   logic [tetris_pkg::SCORE_W-1:0] score;
   logic                           left_final;
   logic                           right_final;
   logic                           rot_final;
   logic                           tick_gravity;

   modport master (
      output key_left_n, key_right_n, key_rot_n, gravity_en, score,
      input  left_final, right_final, rot_final, tick_gravity
   );

   modport slave (
      input  key_left_n, key_right_n, key_rot_n, gravity_en, score,
      output left_final, right_final, rot_final, tick_gravity
   );

endinterface

// File: rtl/tetris_input_ctrl_debounce.sv
// One push-button conditioner: 2-flop synchronizer, debounce counter and press-edge pulse.
module key_debounce
   import tetris_pkg::*;
#(
   parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
   parameter int CNT_W        = CNT_W_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_keyN,
   output logic o_pressed,
   output logic o_pressEdge
);

   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYC - 1);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_stable;
   logic             r_pressEdge;
   logic [CNT_W-1:0] r_cnt;
   logic             w_syncPressed;

   // Bring the raw asynchronous key into the clock domain; idle level is released (1).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= i_keyN;
         r_sync2 <= r_sync1;
      end
   end

   assign w_syncPressed = ~r_sync2;

   // Accept a new level only after it has differed from the stable level for DEBOUNCE_CYC cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stable    <= 1'b0;
         r_cnt       <= '0;
         r_pressEdge <= 1'b0;
      end else begin
         r_pressEdge <= 1'b0;
         if (w_syncPressed == r_stable) begin
            r_cnt <= '0;
         end else if (r_cnt == DEB_LAST) begin
            r_stable    <= w_syncPressed;
            r_cnt       <= '0;
            r_pressEdge <= w_syncPressed;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign o_pressed   = r_stable;
   assign o_pressEdge = r_pressEdge;

endmodule

// File: rtl/tetris_input_ctrl.sv
// Tetris input controller: conditioned key strobes with left/right auto-repeat and a score-scaled gravity tick.
module tetris_input_ctrl
   import tetris_pkg::*;
#(
   parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
   parameter int REPEAT_DELAY = REPEAT_DELAY_DEF,
   parameter int REPEAT_RATE  = REPEAT_RATE_DEF,
   parameter int GRAV_BASE    = GRAV_BASE_DEF,
   parameter int GRAV_STEP    = GRAV_STEP_DEF,
   parameter int GRAV_MIN     = GRAV_MIN_DEF,
   parameter int CNT_W        = CNT_W_DEF
) (
   input logic                 CLOCK_50,
   input logic                 resetn,
   tetris_input_ctrl_if.slave  bus
);

   localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);
   localparam logic [CNT_W:0]   BASE_X     = (CNT_W+1)'(GRAV_BASE);
   localparam logic [CNT_W:0]   STEP_X     = (CNT_W+1)'(GRAV_STEP);
   localparam logic [CNT_W:0]   MIN_X      = (CNT_W+1)'(GRAV_MIN);

   logic [1:0]       w_levelLR;
   logic [1:0]       w_pressLR;
   logic [1:0]       w_moveStrobe;
   logic             w_conflict;
   logic             w_rotPressed;
   logic             w_rotPressEdge;
   logic             r_rotFinal;
   logic [CNT_W:0]   w_gravProd;
   logic [CNT_W:0]   w_gravDiff;
   logic [CNT_W-1:0] w_gravPeriod;
   logic [CNT_W-1:0] w_gravLast;
   logic [CNT_W-1:0] r_gravCnt;
   logic             r_tickGravity;

   key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .CNT_W(CNT_W)) u_keyLeft (
      .clk         (CLOCK_50),
      .rst_n       (resetn),
      .i_keyN      (bus.key_left_n),
      .o_pressed   (w_levelLR[0]),
      .o_pressEdge (w_pressLR[0])
   );

   key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .CNT_W(CNT_W)) u_keyRight (
      .clk         (CLOCK_50),
      .rst_n       (resetn),
      .i_keyN      (bus.key_right_n),
      .o_pressed   (w_levelLR[1]),
      .o_pressEdge (w_pressLR[1])
   );

   key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .CNT_W(CNT_W)) u_keyRot (
      .clk         (CLOCK_50),
      .rst_n       (resetn),
      .i_keyN      (bus.key_rot_n),
      .o_pressed   (w_rotPressed),
      .o_pressEdge (w_rotPressEdge)
   );

   assign w_conflict = w_levelLR[0] & w_levelLR[1];

   for (genvar d = 0; d < 2; d++) begin : g_repeat
      rptState_t        r_state;
      logic [CNT_W-1:0] r_cnt;
      logic             r_strobe;

      // Auto-repeat for one direction; holding both directions or releasing parks it in IDLE.
      always_ff @(posedge CLOCK_50 or negedge resetn) begin
         if (!resetn) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_strobe <= 1'b0;
         end else if (w_conflict || !w_levelLR[d]) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_strobe <= 1'b0;
         end else begin
            r_strobe <= 1'b0;
            case (r_state)
               IDLE: begin
                  if (w_pressLR[d]) begin
                     r_state  <= DELAY;
                     r_cnt    <= '0;
                     r_strobe <= 1'b1;
                  end
               end
               DELAY: begin
                  if (r_cnt == DELAY_LAST) begin
                     r_state  <= REPEAT;
                     r_cnt    <= '0;
                     r_strobe <= 1'b1;
                  end else begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
               REPEAT: begin
                  if (r_cnt == RATE_LAST) begin
                     r_cnt    <= '0;
                     r_strobe <= 1'b1;
                  end else begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
               default: begin
                  r_state <= IDLE;
                  r_cnt   <= '0;
               end
            endcase
         end
      end

      assign w_moveStrobe[d] = r_strobe;
   end

   // Rotate strobe is the registered press edge of the held key, with no repeat.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         r_rotFinal <= 1'b0;
      end else begin
         r_rotFinal <= w_rotPressEdge & w_rotPressed;
      end
   end

   assign w_gravProd   = (CNT_W+1)'(bus.score) * STEP_X;
   assign w_gravDiff   = BASE_X - w_gravProd;
   assign w_gravPeriod = (w_gravDiff[CNT_W] || (w_gravDiff < MIN_X)) ? MIN_X[CNT_W-1:0]
                                                                      : w_gravDiff[CNT_W-1:0];
   assign w_gravLast   = w_gravPeriod - CNT_W'(1);

   // Gravity divider; the >= compare lets a shortened period take effect immediately.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         r_gravCnt     <= '0;
         r_tickGravity <= 1'b0;
      end else if (!bus.gravity_en) begin
         r_gravCnt     <= '0;
         r_tickGravity <= 1'b0;
      end else if (r_gravCnt >= w_gravLast) begin
         r_gravCnt     <= '0;
         r_tickGravity <= 1'b1;
      end else begin
         r_gravCnt     <= r_gravCnt + CNT_W'(1);
         r_tickGravity <= 1'b0;
      end
   end

   assign bus.left_final   = w_moveStrobe[0];
   assign bus.right_final  = w_moveStrobe[1];
   assign bus.rot_final    = r_rotFinal;
   assign bus.tick_gravity = r_tickGravity;

endmodule

// File: tb/tb_tetris_input_ctrl.sv
// Testbench for tetris_input_ctrl: per-cycle behavioural model plus directed timing checks.
module tb_tetris_input_ctrl;
   import tetris_pkg::*;

   localparam int DEB = 4;
   localparam int RD  = 10;
   localparam int RR  = 3;
   localparam int GB  = 20;
   localparam int GS  = 2;
   localparam int GM  = 6;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   tetris_input_ctrl_if bus();

   tetris_input_ctrl #(
      .DEBOUNCE_CYC (DEB),
      .REPEAT_DELAY (RD),
      .REPEAT_RATE  (RR),
      .GRAV_BASE    (GB),
      .GRAV_STEP    (GS),
      .GRAV_MIN     (GM),
      .CNT_W        (26)
   ) dut (
      .CLOCK_50 (clk),
      .resetn   (resetn),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   int tL[$];
   int tR[$];
   int tRot[$];
   int tG[$];

   // Model state: key index 0=left, 1=right, 2=rotate
   logic [2:0] mS1 = '0;
   logic [2:0] mS2 = '0;
   logic [2:0] mDb = '0;
   logic [2:0] mPressEv = '0;
   int         mRun[3] = '{0, 0, 0};
   logic [1:0] mArmed = '0;
   int         mStart[2] = '{0, 0};
   int         mGCnt = 0;
   logic [1:0] expMove = '0;
   logic       expRot = 1'b0;
   logic       expGrav = 1'b0;

   task automatic checkOutput(input string name, input int actual, input int expected);
      tests++;
      if (actual != expected) begin
         fails++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   task automatic applyStimulus(input logic l, input logic r, input logic rt,
                                input logic en, input logic [4:0] sc, input int n);
      bus.key_left_n  = l;
      bus.key_right_n = r;
      bus.key_rot_n   = rt;
      bus.gravity_en  = en;
      bus.score       = sc;
      repeat (n) @(negedge clk);
      #1;
   endtask

   // Behavioural model stepped on each rising edge from the inputs held at that edge
   always @(posedge clk) begin
      logic [2:0] rawP;
      logic       conflict;
      logic       seen;
      int         el;
      int         period;
      cyc++;
      if (!resetn) begin
         mS1 = '0; mS2 = '0; mDb = '0; mPressEv = '0;
         mRun = '{0, 0, 0};
         mArmed = '0; mGCnt = 0;
         expMove = '0; expRot = 1'b0; expGrav = 1'b0;
      end else begin
         rawP = ~{bus.key_rot_n, bus.key_right_n, bus.key_left_n};
         conflict = mDb[0] & mDb[1];
         for (int d = 0; d < 2; d++) begin
            if (conflict || !mDb[d]) begin
               mArmed[d] = 1'b0;
               expMove[d] = 1'b0;
            end else if (!mArmed[d]) begin
               expMove[d] = mPressEv[d];
               if (mPressEv[d]) begin
                  mArmed[d] = 1'b1;
                  mStart[d] = cyc;
               end
            end else begin
               el = cyc - mStart[d];
               expMove[d] = (el == RD) || (el > RD && ((el - RD) % RR) == 0);
            end
         end
         expRot = mPressEv[2];
         for (int k = 0; k < 3; k++) begin
            seen = mS2[k];
            mPressEv[k] = 1'b0;
            if (seen != mDb[k]) mRun[k]++;
            else mRun[k] = 0;
            if (mRun[k] == DEB) begin
               mDb[k] = seen;
               mRun[k] = 0;
               mPressEv[k] = seen;
            end
         end
         mS2 = mS1;
         mS1 = rawP;
         period = GB - int'(bus.score) * GS;
         if (period < GM) period = GM;
         if (!bus.gravity_en) begin
            mGCnt = 0;
            expGrav = 1'b0;
         end else begin
            mGCnt++;
            expGrav = (mGCnt >= period);
            if (expGrav) mGCnt = 0;
         end
      end
   end

   // Compare every output against the model on each falling edge and log strobe times
   always @(negedge clk) begin
      checkOutput("left_final",   int'(bus.left_final),   int'(expMove[0] & resetn));
      checkOutput("right_final",  int'(bus.right_final),  int'(expMove[1] & resetn));
      checkOutput("rot_final",    int'(bus.rot_final),    int'(expRot & resetn));
      checkOutput("tick_gravity", int'(bus.tick_gravity), int'(expGrav & resetn));
      if (bus.left_final)   tL.push_back(cyc);
      if (bus.right_final)  tR.push_back(cyc);
      if (bus.rot_final)    tRot.push_back(cyc);
      if (bus.tick_gravity) tG.push_back(cyc);
   end

   function automatic int countAfter(input int q[$], input int t);
      int n = 0;
      foreach (q[i]) if (q[i] > t) n++;
      return n;
   endfunction

   function automatic int gap(input int q[$], input int a, input int b);
      if (q.size() > b) return q[b] - q[a];
      return -1;
   endfunction

   // Directed scenarios
   initial begin
      int t0, t1, t3, te;
      int offs[5] = '{0, 10, 13, 16, 19};

      applyStimulus(1, 1, 1, 0, 5'd0, 3);
      checkOutput("reset_left",  int'(bus.left_final),   0);
      checkOutput("reset_right", int'(bus.right_final),  0);
      checkOutput("reset_rot",   int'(bus.rot_final),    0);
      checkOutput("reset_grav",  int'(bus.tick_gravity), 0);
      resetn = 1'b1;
      applyStimulus(1, 1, 1, 0, 5'd0, 5);

      // Rotate: single strobe at latency 7
      t0 = cyc;
      applyStimulus(1, 1, 0, 0, 5'd0, 20);
      checkOutput("rot_count", tRot.size(), 1);
      checkOutput("rot_latency", (tRot.size() > 0) ? tRot[0] - t0 : -1, 7);
      applyStimulus(1, 1, 1, 0, 5'd0, 12);

      // Left glitches are ignored, then a clean hold
      for (int i = 0; i < 5; i++) begin
         applyStimulus(0, 1, 1, 0, 5'd0, 3);
         applyStimulus(1, 1, 1, 0, 5'd0, 3);
      end
      applyStimulus(1, 1, 1, 0, 5'd0, 8);
      checkOutput("glitch_none", tL.size(), 0);
      t0 = cyc;
      applyStimulus(0, 1, 1, 0, 5'd0, 20);
      applyStimulus(1, 1, 1, 0, 5'd0, 12);
      checkOutput("left_first", (tL.size() > 0) ? tL[0] - t0 : -1, 7);
      checkOutput("left_repeat_delay", gap(tL, 0, 1), 10);
      checkOutput("left_count", tL.size(), 5);

      // Right long hold: repeat cadence and clean stop after release
      t0 = cyc;
      applyStimulus(1, 0, 1, 0, 5'd0, 50);
      applyStimulus(1, 1, 1, 0, 5'd0, 15);
      checkOutput("right_first", (tR.size() > 0) ? tR[0] - t0 : -1, 7);
      for (int i = 1; i < 5; i++) checkOutput("right_offset", gap(tR, 0, i), offs[i]);
      checkOutput("right_count", tR.size(), 15);

      // Left/right conflict
      tL.delete(); tR.delete();
      applyStimulus(0, 1, 1, 0, 5'd0, 25);
      t1 = cyc;
      applyStimulus(0, 0, 1, 0, 5'd0, 20);
      applyStimulus(0, 1, 1, 0, 5'd0, 20);
      applyStimulus(1, 1, 1, 0, 5'd0, 12);
      checkOutput("conflict_left_quiet", countAfter(tL, t1 + 6), 0);
      checkOutput("conflict_right_none", tR.size(), 0);
      t3 = cyc;
      applyStimulus(0, 1, 1, 0, 5'd0, 10);
      applyStimulus(1, 1, 1, 0, 5'd0, 12);
      checkOutput("repress_left", countAfter(tL, t3), 1);

      // Gravity periods
      tG.delete();
      te = cyc;
      applyStimulus(1, 1, 1, 1, 5'd0, 65);
      checkOutput("grav_first_s0", (tG.size() > 0) ? tG[0] - te : -1, 20);
      checkOutput("grav_period_s0", gap(tG, 0, 1), 20);
      tG.delete();
      applyStimulus(1, 1, 1, 1, 5'd5, 35);
      checkOutput("grav_period_s5", gap(tG, 1, 2), 10);
      tG.delete();
      applyStimulus(1, 1, 1, 1, 5'd31, 25);
      checkOutput("grav_period_s31", gap(tG, 1, 2), 6);
      tG.delete();
      applyStimulus(1, 1, 1, 0, 5'd0, 50);
      checkOutput("grav_disabled", tG.size(), 0);
      te = cyc;
      applyStimulus(1, 1, 1, 1, 5'd0, 25);
      checkOutput("grav_reenable", (tG.size() > 0) ? tG[0] - te : -1, 20);
      applyStimulus(1, 1, 1, 0, 5'd0, 3);
      tG.delete();
      te = cyc;
      applyStimulus(1, 1, 1, 1, 5'd0, 12);
      applyStimulus(1, 1, 1, 1, 5'd7, 20);
      checkOutput("grav_score_jump", (tG.size() > 0) ? tG[0] - te : -1, 13);
      checkOutput("grav_after_jump", gap(tG, 0, 1), 6);
      applyStimulus(1, 1, 1, 0, 5'd0, 3);

      // Reset in the middle of a left repeat
      applyStimulus(0, 1, 1, 0, 5'd0, 25);
      resetn = 1'b0;
      applyStimulus(0, 1, 1, 0, 5'd0, 3);
      checkOutput("midreset_left", int'(bus.left_final), 0);
      tL.delete();
      resetn = 1'b1;
      t0 = cyc;
      applyStimulus(0, 1, 1, 0, 5'd0, 9);
      checkOutput("postreset_left", (tL.size() > 0) ? tL[0] - t0 : -1, 7);
      checkOutput("postreset_count", tL.size(), 1);
      applyStimulus(1, 1, 1, 0, 5'd0, 12);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
